// File: rtl/within_checker.sv
// Checks "a |=> (b[*N_B] within c[+]) ##1 d" one evaluation at a time,
// emitting registered pass/fail pulses plus saturating event counters.
module within_checker #(
  parameter int N_B     = 3,
  parameter int MAX_WIN = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [2:0] fail_code,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [7:0] drop_cnt
);

  typedef enum logic {IDLE, WIN} state_t;

  localparam logic [3:0] NB4 = 4'(N_B);
  localparam logic [7:0] MW8 = 8'(MAX_WIN);

  state_t     state, state_nx;
  logic [3:0] bcnt, bcnt_nx, bcnt_b;
  logic       seen, seen_nx, armed, armed_nx;
  logic [7:0] win_len, win_len_nx, win_inc;
  logic       pass_nx, fail_nx, drop;
  logic [2:0] code_nx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : 8'(v + 8'd1);
  endfunction

  always_comb begin
    state_nx   = state;
    bcnt_nx    = bcnt;
    seen_nx    = seen;
    armed_nx   = armed;
    win_len_nx = win_len;
    win_inc    = win_len;
    bcnt_b     = bcnt;
    pass_nx    = 1'b0;
    fail_nx    = 1'b0;
    code_nx    = fail_code;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (a) begin
          state_nx   = WIN;
          bcnt_nx    = 4'd0;
          seen_nx    = 1'b0;
          armed_nx   = 1'b0;
          win_len_nx = 8'd0;
        end
      end
      WIN: begin
        drop       = a;
        win_inc    = (win_len >= MW8) ? MW8 : 8'(win_len + 8'd1);
        win_len_nx = win_inc;
        bcnt_b     = b ? ((bcnt >= NB4) ? NB4 : 4'(bcnt + 4'd1)) : 4'd0;
        // Verdict priority: pass beats a c=0 fail, which beats timeout.
        if (armed && d) begin
          pass_nx  = 1'b1;
          state_nx = IDLE;
        end else if (!c) begin
          fail_nx  = 1'b1;
          state_nx = IDLE;
          if (win_inc == 8'd1) code_nx = 3'd1;
          else if (!seen)      code_nx = 3'd2;
          else                 code_nx = 3'd3;
        end else if (win_inc == MW8) begin
          fail_nx  = 1'b1;
          state_nx = IDLE;
          code_nx  = 3'd4;
        end else begin
          bcnt_nx  = bcnt_b;
          seen_nx  = seen | (bcnt_b == NB4);
          armed_nx = seen | (bcnt_b == NB4);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bcnt      <= 4'd0;
      seen      <= 1'b0;
      armed     <= 1'b0;
      win_len   <= 8'd0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 3'd0;
      pass_cnt  <= 8'd0;
      fail_cnt  <= 8'd0;
      drop_cnt  <= 8'd0;
    end else begin
      state     <= state_nx;
      bcnt      <= bcnt_nx;
      seen      <= seen_nx;
      armed     <= armed_nx;
      win_len   <= win_len_nx;
      pass      <= pass_nx;
      fail      <= fail_nx;
      fail_code <= code_nx;
      if (pass_nx) pass_cnt <= sat_inc8(pass_cnt);
      if (fail_nx) fail_cnt <= sat_inc8(fail_cnt);
      if (drop)    drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  assign busy = (state == WIN);

endmodule

// File: tb/tb_within_checker.sv
// Directed bench for within_checker: a default instance (N_B=3, MAX_WIN=64)
// and a short-timeout instance (MAX_WIN=8) share the same input trace.
module tb_within_checker;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic busy, pass, fail;
  logic [2:0] fail_code;
  logic [7:0] pass_cnt, fail_cnt, drop_cnt;
  logic t_busy, t_pass, t_fail;
  logic [2:0] t_fail_code;
  logic [7:0] t_pass_cnt, t_fail_cnt, t_drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int o_npass, o_nfail, o_pass_e, o_fail_e, o_code, o_both, o_busy1;
  int o_t_fail_e, o_t_code;

  within_checker #(.N_B(3), .MAX_WIN(64)) dut (
    .clock(clock), .resetn(resetn), .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt));

  within_checker #(.N_B(3), .MAX_WIN(8)) dut_t (
    .clock(clock), .resetn(resetn), .a(a), .b(b), .c(c), .d(d),
    .busy(t_busy), .pass(t_pass), .fail(t_fail), .fail_code(t_fail_code),
    .pass_cnt(t_pass_cnt), .fail_cnt(t_fail_cnt), .drop_cnt(t_drop_cnt));

  always #5 clock = ~clock;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    resetn = 1'b0; a = 0; b = 0; c = 0; d = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // Bit e of each vector is the value sampled at edge e.
  task automatic run_trace(input logic [63:0] av, bv, cv, dv, input int n);
    o_npass = 0; o_nfail = 0; o_pass_e = -1; o_fail_e = -1; o_code = -1;
    o_both = 0; o_busy1 = -1; o_t_fail_e = -1; o_t_code = -1;
    for (int e = 1; e <= n; e++) begin
      @(negedge clock);
      a = av[e]; b = bv[e]; c = cv[e]; d = dv[e];
      @(posedge clock);
      #1;
      if (e == 1) o_busy1 = int'(busy);
      if (pass) begin o_npass++; if (o_pass_e < 0) o_pass_e = e; end
      if (fail) begin o_nfail++; if (o_fail_e < 0) begin o_fail_e = e; o_code = int'(fail_code); end end
      if (pass && fail) o_both++;
      if (t_fail && o_t_fail_e < 0) begin o_t_fail_e = e; o_t_code = int'(t_fail_code); end
    end
    @(negedge clock);
    a = 0; b = 0; c = 0; d = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if ({pass, fail} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got=%b want=00", {pass, fail}); end
    n_cmp++; if (fail_code !== 3'd0) begin n_bad++; $display("FAIL reset_code got=%0d want=0", fail_code); end
    n_cmp++; if ({pass_cnt, fail_cnt, drop_cnt} !== 24'd0) begin n_bad++;
      $display("FAIL reset_cnts got=%0d/%0d/%0d want=0/0/0", pass_cnt, fail_cnt, drop_cnt); end
  endtask

  task automatic test_pass_late();
    apply_reset();
    run_trace(rng(1,1), rng(5,7), rng(2,12), rng(6,6) | rng(13,13), 15);
    n_cmp++; if (o_busy1 !== 1) begin n_bad++; $display("FAIL late_busy got=%0d want=1", o_busy1); end
    n_cmp++; if (o_pass_e !== 13) begin n_bad++; $display("FAIL late_pass_edge got=%0d want=13", o_pass_e); end
    n_cmp++; if (o_npass !== 1 || o_nfail !== 0) begin n_bad++;
      $display("FAIL late_pulses got=%0d/%0d want=1/0", o_npass, o_nfail); end
    n_cmp++; if (pass_cnt !== 8'd1) begin n_bad++; $display("FAIL late_pass_cnt got=%0d want=1", pass_cnt); end
  endtask

  task automatic test_pass_end();
    apply_reset();
    run_trace(rng(1,1), rng(5,7), rng(2,7), rng(8,8), 10);
    n_cmp++; if (o_pass_e !== 8 || o_nfail !== 0) begin n_bad++;
      $display("FAIL end_pass got=%0d nfail=%0d want=8 nfail=0", o_pass_e, o_nfail); end
  endtask

  task automatic test_fail_seen();
    apply_reset();
    run_trace(rng(1,1), rng(5,7), rng(2,12), rng(7,7), 15);
    n_cmp++; if (o_fail_e !== 13 || o_code !== 3) begin n_bad++;
      $display("FAIL seen_fail got=%0d code=%0d want=13 code=3", o_fail_e, o_code); end
    n_cmp++; if (o_npass !== 0) begin n_bad++; $display("FAIL seen_npass got=%0d want=0", o_npass); end
  endtask

  task automatic test_b_outside();
    apply_reset();
    run_trace(rng(1,1), rng(1,3), rng(2,6), rng(7,7), 9);
    n_cmp++; if (o_fail_e !== 7 || o_code !== 2 || o_npass !== 0) begin n_bad++;
      $display("FAIL outside_fail got=%0d code=%0d np=%0d want=7 code=2 np=0", o_fail_e, o_code, o_npass); end
  endtask

  task automatic test_b_inside();
    apply_reset();
    run_trace(rng(1,1), rng(2,4), rng(2,6), rng(7,7), 9);
    n_cmp++; if (o_pass_e !== 7 || o_nfail !== 0) begin n_bad++;
      $display("FAIL inside_pass got=%0d nfail=%0d want=7 nfail=0", o_pass_e, o_nfail); end
  endtask

  task automatic test_no_c();
    apply_reset();
    run_trace(rng(1,1), '0, '0, '0, 5);
    n_cmp++; if (o_fail_e !== 2 || o_code !== 1 || o_nfail !== 1) begin n_bad++;
      $display("FAIL noc_fail got=%0d code=%0d n=%0d want=2 code=1 n=1", o_fail_e, o_code, o_nfail); end
    n_cmp++; if (fail_code !== 3'd1 || fail_cnt !== 8'd1) begin n_bad++;
      $display("FAIL noc_hold got code=%0d cnt=%0d want code=1 cnt=1", fail_code, fail_cnt); end
  endtask

  task automatic test_drop();
    apply_reset();
    run_trace(rng(1,1) | rng(3,3), rng(2,4), rng(2,6), rng(7,7), 9);
    n_cmp++; if (o_npass !== 1 || o_pass_e !== 7) begin n_bad++;
      $display("FAIL drop_pass got=%0d@%0d want=1@7", o_npass, o_pass_e); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL drop_cnt got=%0d want=1", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_trace(rng(1,1) | rng(7,8), rng(2,4), rng(2,6), rng(7,7), 12);
    n_cmp++; if (o_pass_e !== 7 || o_fail_e !== 9 || o_code !== 1) begin n_bad++;
      $display("FAIL b2b got pass=%0d fail=%0d code=%0d want 7/9/1", o_pass_e, o_fail_e, o_code); end
    n_cmp++; if ({pass_cnt, fail_cnt, drop_cnt} !== {8'd1, 8'd1, 8'd1}) begin n_bad++;
      $display("FAIL b2b_cnts got=%0d/%0d/%0d want=1/1/1", pass_cnt, fail_cnt, drop_cnt); end
    n_cmp++; if (o_both !== 0) begin n_bad++; $display("FAIL b2b_exclusive got=%0d want=0", o_both); end
  endtask

  task automatic test_timeout();
    apply_reset();
    run_trace(rng(1,1), '0, rng(2,12), '0, 12);
    n_cmp++; if (o_t_fail_e !== 9 || o_t_code !== 4) begin n_bad++;
      $display("FAIL timeout got=%0d code=%0d want=9 code=4", o_t_fail_e, o_t_code); end
    apply_reset();
    run_trace(rng(1,1), '0, rng(2,8), '0, 12);
    n_cmp++; if (o_t_fail_e !== 9 || o_t_code !== 2) begin n_bad++;
      $display("FAIL timeout_vs_c got=%0d code=%0d want=9 code=2", o_t_fail_e, o_t_code); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    apply_reset();
    for (int e = 1; e <= 3; e++) begin
      @(negedge clock);
      a = (e <= 2); c = (e >= 2);
    end
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b1 || drop_cnt !== 8'd1) begin n_bad++;
      $display("FAIL mid_pre got busy=%b drop=%0d want busy=1 drop=1", busy, drop_cnt); end
    @(negedge clock);
    resetn = 1'b0; a = 0;
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b0 || {pass, fail} !== 2'b00) begin n_bad++;
      $display("FAIL mid_reset got busy=%b pf=%b want busy=0 pf=00", busy, {pass, fail}); end
    @(negedge clock);
    resetn = 1'b1; c = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clock); #1;
      if (pass || fail || busy) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_after got=%0d want=0", pulses); end
    n_cmp++; if ({pass_cnt, fail_cnt, drop_cnt} !== 24'd0) begin n_bad++;
      $display("FAIL mid_cnts got=%0d/%0d/%0d want=0/0/0", pass_cnt, fail_cnt, drop_cnt); end
    run_trace(rng(1,1), '0, '0, '0, 4);
    n_cmp++; if (o_fail_e !== 2 || o_code !== 1) begin n_bad++;
      $display("FAIL mid_restart got=%0d code=%0d want=2 code=1", o_fail_e, o_code); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int e = 1; e <= 600; e++) begin
      @(negedge clock);
      a = 1'b1; c = 1'b1;
    end
    @(posedge clock); #1;
    n_cmp++; if (t_drop_cnt !== 8'd255 || drop_cnt !== 8'd255) begin n_bad++;
      $display("FAIL sat_drop got=%0d/%0d want=255/255", t_drop_cnt, drop_cnt); end
    n_cmp++; if (t_fail_cnt !== 8'd66 || t_pass_cnt !== 8'd0) begin n_bad++;
      $display("FAIL sat_fail got=%0d pass=%0d want=66 pass=0", t_fail_cnt, t_pass_cnt); end
    @(negedge clock);
    a = 0; c = 0;
  endtask

  initial begin
    test_reset();
    test_pass_late();
    test_pass_end();
    test_fail_seen();
    test_b_outside();
    test_b_inside();
    test_no_c();
    test_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/within_checker.md
WITHIN_CHECKER -- requirements
Module: within_checker

Interface
REQ-001 SHALL have parameter N_B, default 3, giving the required consecutive-B run length (1..15).
REQ-002 SHALL have parameter MAX_WIN, default 64, giving the maximum window length in cycles before timeout (2..255).
REQ-003 SHALL have port clock  input  1  the single clock; all sampling is on the rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports a, b, c, d  input  1 each  trace signals from the upstream sequencer stage.
REQ-006 SHALL have port busy  output  1  high while an evaluation window is open.
REQ-007 SHALL have ports pass, fail  output  1 each  single-cycle verdict pulses, mutually exclusive.
REQ-008 SHALL have port fail_code  output  3  cause of the last fail; held until the next fail.
REQ-009 SHALL have ports pass_cnt, fail_cnt, drop_cnt  output  8 each  saturating event counters.

Function
REQ-010 SHALL check the property "a |=> (b[*N_B] within c[+]) ##1 d" in RTL, one evaluation at a time.
REQ-011 SHALL use two states: IDLE and WIN; busy = (state == WIN).
REQ-012 In IDLE, a=1 at edge t SHALL move to WIN and clear bcnt, seen, armed, win_len; evaluation starts at edge t+1.
REQ-013 In WIN, each edge k SHALL first increment win_len, saturating at MAX_WIN, then evaluate in strict priority order:
 (1) armed && d -> pass;
 (2) !c -> fail;
 (3) win_len == MAX_WIN -> fail, code 4;
 (4) otherwise stay in WIN.
REQ-014 When c=1 and there is no verdict, the block SHALL update bcnt = b ? min(bcnt+1, N_B) : 0, set seen |= (bcnt_new == N_B), and set armed = seen_new.
REQ-015 B cycles outside the window (before t+1) SHALL NOT count toward bcnt.
REQ-016 fail_code SHALL be set on a c=0 fail as follows: 1 when win_len == 1 (no c[+]); 2 when seen = 0 (B run not within C); 3 when seen = 1 (d absent after every valid end).
REQ-017 A verdict at edge k SHALL produce a pass or fail pulse during cycle k+1, with the state back in IDLE at k+1.
REQ-018 a=1 in IDLE at edge k+1 SHALL be accepted, so back-to-back evaluations are possible.
REQ-019 a=1 sampled while in WIN, including at the verdict edge, SHALL be ignored and increment drop_cnt.
REQ-020 The counters SHALL increment on the edge that raises pass, fail, or the drop and SHALL saturate at 255, without wrapping.
REQ-021 The simultaneous conditions armed && d && !c SHALL resolve as pass.
REQ-022 When timeout and c=0 occur together, the c=0 fail code SHALL take precedence over code 4.
REQ-023 The block SHALL be purely synchronous apart from reset, with no combinational path from inputs to outputs.

Reset
REQ-024 resetn=0 SHALL asynchronously force state=IDLE, busy=0, pass=0, fail=0, fail_code=0, all counters=0, and bcnt/seen/armed/win_len=0.
REQ-025 Reset asserted mid-window SHALL abandon the evaluation with no verdict pulse.
REQ-026 After reset release, the first a=1 SHALL be accepted normally.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (N_B=3; cycle = edge index):
 - Trace a@1, b@5-7, c@2-12, d@6,13 -> no verdict at 6 (not armed), pass at edge 13, pass_cnt=1.
 - Trace a@1, b@5-7, c@2-7, d@8 -> pass at edge 8.
 - Trace a@1, b@5-7, c@2-12, d@7 -> fail at edge 13, fail_code=3.
 - Trace a@1, b@1-3, c@2-6, d@7 -> fail at edge 7, fail_code=2 (b@1 not counted).
 - Trace a@1, b@2-4, c@2-6, d@7 -> pass at edge 7.
 - Trace a@1 with c low at 2 -> fail at edge 2, fail_code=1.
 - Trace a@1 and a@3, b@2-4, c@2-6, d@7 -> single pass, drop_cnt=1.
 - MAX_WIN=8, a@1, c held high, b low -> fail at edge 9, fail_code=4.
 - resetn pulsed low at edge 4 of a window -> busy=0, no pass/fail pulse, all counters=0.
